// File: rtl/br_res_queue.sv
// Branch resolution queue: holds in-flight predictions in order and turns
// each resolve into a predictor update and, on a mispredict, a GHR repair.
module br_res_queue #(
  parameter int DEPTH  = 8,
  parameter int GHR_W  = 14,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pre_valid,
  input  logic [ADDR_W-1:0]          pre_addr,
  input  logic                       pre_torn,
  input  logic [GHR_W-1:0]           pre_ghr,
  output logic                       pre_ready,
  input  logic                       res_valid,
  input  logic                       res_torn,
  output logic [ADDR_W-1:0]          up_addr,
  output logic                       PAs_up_en,
  output logic                       PAs_wr_data,
  output logic                       torf,
  output logic                       gshare_reen,
  output logic [GHR_W-1:0]           re_GHR,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       res_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ACTIVE,
    S_FULL,
    S_RECOVER
  } state_e;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              torn_mem [DEPTH];
  logic [GHR_W-1:0]  ghr_mem  [DEPTH];

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] up_addr_q;
  logic              up_en_q;
  logic              wr_data_q;
  logic              torf_q;
  logic              reen_q;
  logic [GHR_W-1:0]  re_ghr_q;
  logic              err_q;

  logic pop, push, mispred, head_torn;

  assign head_torn = torn_mem[head_q];
  assign pre_ready = (state_q == S_EMPTY) || (state_q == S_ACTIVE);

  always_comb begin
    pop     = res_valid && (count_q != '0);
    mispred = pop && (res_torn != head_torn);
    push    = pre_valid && pre_ready && !mispred;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (mispred) begin
      // Younger entries were fetched down the wrong path: drop them all.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = S_RECOVER;
    end else begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d == '0) begin
        state_d = S_EMPTY;
      end else if (count_d == CW'(DEPTH)) begin
        state_d = S_FULL;
      end else begin
        state_d = S_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= pre_addr;
      torn_mem[tail_q] <= pre_torn;
      ghr_mem[tail_q]  <= pre_ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      up_addr_q <= '0;
      up_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      torf_q    <= 1'b1;
      reen_q    <= 1'b0;
      re_ghr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      up_en_q <= pop;
      reen_q  <= mispred;
      err_q   <= res_valid && (count_q == '0);
      if (pop) begin
        up_addr_q <= addr_mem[head_q];
        wr_data_q <= res_torn;
        torf_q    <= (res_torn == head_torn);
      end
      if (mispred) begin
        re_ghr_q <= {ghr_mem[head_q][GHR_W-2:0], res_torn};
      end
    end
  end

  assign up_addr     = up_addr_q;
  assign PAs_up_en   = up_en_q;
  assign PAs_wr_data = wr_data_q;
  assign torf        = torf_q;
  assign gshare_reen = reen_q;
  assign re_GHR      = re_ghr_q;
  assign count       = count_q;
  assign res_err     = err_q;

endmodule

// File: tb/tb_br_res_queue.sv
// Scoreboard bench for br_res_queue: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_br_res_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_valid;
  logic [31:0] pre_addr;
  logic        pre_torn;
  logic [13:0] pre_ghr;
  logic        pre_ready;
  logic        res_valid;
  logic        res_torn;
  logic [31:0] up_addr;
  logic        PAs_up_en;
  logic        PAs_wr_data;
  logic        torf;
  logic        gshare_reen;
  logic [13:0] re_GHR;
  logic [3:0]  count;
  logic        res_err;

  br_res_queue #(.DEPTH(DEPTH), .GHR_W(14), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .pre_valid(pre_valid), .pre_addr(pre_addr),
    .pre_torn(pre_torn), .pre_ghr(pre_ghr),
    .pre_ready(pre_ready),
    .res_valid(res_valid), .res_torn(res_torn),
    .up_addr(up_addr), .PAs_up_en(PAs_up_en),
    .PAs_wr_data(PAs_wr_data), .torf(torf),
    .gshare_reen(gshare_reen), .re_GHR(re_GHR),
    .count(count), .res_err(res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        torn;
    logic [13:0] ghr;
  } ent_t;

  typedef struct {
    bit          err;
    logic [31:0] addr;
    logic        wr;
    logic        torf;
    logic        reen;
    logic [13:0] reghr;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  bit   recover;
  logic last_torf;
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   started = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endfunction

  function automatic logic head_torn();
    return (mq.size() > 0) ? mq[0].torn : 1'b0;
  endfunction

  // One clock: check occupancy, drive inputs, advance the model.
  task automatic cycle(input logic pv, input logic [31:0] a,
                       input logic t, input logic [13:0] g,
                       input logic rv, input logic rt,
                       input logic rst);
    bit   prdy;
    exp_t e;
    ent_t h;
    prdy = !recover && (mq.size() < DEPTH);
    chk("count", 32'(count), 32'(mq.size()));
    chk("pre_ready", 32'(pre_ready), 32'(prdy));
    pre_valid = pv; pre_addr = a; pre_torn = t; pre_ghr = g;
    res_valid = rv; res_torn = rt; reset = rst;
    if (rst) begin
      mq.delete();
      recover = 0;
      last_torf = 1'b1;
    end else begin
      recover = 0;
      if (rv && mq.size() == 0) begin
        e = '{err: 1, addr: 0, wr: 0, torf: last_torf, reen: 0, reghr: 0};
        expq.push_back(e);
        if (pv && prdy) mq.push_back('{a, t, g});
      end else if (rv) begin
        h = mq.pop_front();
        last_torf = (h.torn == rt);
        e = '{err: 0, addr: h.addr, wr: rt, torf: last_torf,
              reen: !last_torf, reghr: {h.ghr[12:0], rt}};
        expq.push_back(e);
        if (!last_torf) begin
          mq.delete();
          recover = 1;
        end else if (pv && prdy) begin
          mq.push_back('{a, t, g});
        end
      end else if (pv && prdy) begin
        mq.push_back('{a, t, g});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: consumes an expectation whenever the DUT emits a pulse.
  always @(negedge clk) begin
    exp_t e;
    if (started && (PAs_up_en === 1'b1 || res_err === 1'b1 ||
                    gshare_reen === 1'b1)) begin
      if (expq.size() == 0) begin
        n_tot++;
        $display("FAIL spurious_pulse: up_en=%b err=%b reen=%b expected none",
                 PAs_up_en, res_err, gshare_reen);
      end else begin
        e = expq.pop_front();
        chk("res_err", 32'(res_err), 32'(e.err));
        chk("up_en", 32'(PAs_up_en), 32'(!e.err));
        chk("torf", 32'(torf), 32'(e.torf));
        if (!e.err) begin
          chk("up_addr", up_addr, e.addr);
          chk("wr_data", 32'(PAs_wr_data), 32'(e.wr));
          chk("reen", 32'(gshare_reen), 32'(e.reen));
          if (e.reen) chk("re_ghr", 32'(re_GHR), 32'(e.reghr));
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        rv;
    recover = 0;
    last_torf = 1'b1;
    reset = 1; pre_valid = 0; pre_addr = 0; pre_torn = 0; pre_ghr = 0;
    res_valid = 0; res_torn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    started = 1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(pre_ready), 1);
    chk("rst_torf", 32'(torf), 1);
    chk("rst_reghr", 32'(re_GHR), 0);
    chk("rst_upaddr", up_addr, 0);

    // In-order correct resolves
    cycle(1, 32'h100, 1, 14'h11, 0, 0, 0);
    cycle(1, 32'h104, 0, 14'h12, 0, 0, 0);
    cycle(1, 32'h108, 1, 14'h13, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    idle(2);

    // Fill, overflow attempt, resolve while full
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 32'h200 + 32'(4 * i), 1'(i), 14'(i), 0, 0, 0);
    chk("full_ready", 32'(pre_ready), 0);
    cycle(1, 32'hBAD, 0, 0, 0, 0, 0);
    cycle(1, 32'hBAD0, 1, 0, 1, head_torn(), 0);
    chk("full_pop_count", 32'(count), 7);
    while (mq.size() > 0) cycle(0, 0, 0, 0, 1, head_torn(), 0);
    idle(1);

    // Mispredict flush and GHR repair
    cycle(1, 32'h300, 1, 14'h0005, 0, 0, 0);
    for (int i = 1; i < 4; i++)
      cycle(1, 32'h300 + 32'(4 * i), 0, 14'h7, 0, 0, 0);
    cycle(1, 32'h3F0, 0, 0, 1, 0, 0);
    chk("mp_reghr", 32'(re_GHR), 32'h000A);
    chk("mp_reen", 32'(gshare_reen), 1);
    chk("mp_torf", 32'(torf), 0);
    idle(2);

    // Resolve on empty
    cycle(0, 0, 0, 0, 1, 1, 0);
    chk("empty_err", 32'(res_err), 1);
    idle(2);

    // Wraparound with interleaved resolves
    for (int i = 0; i < 20; i++) begin
      rv = (i % 2 == 1) && (mq.size() > 0);
      cycle(1, 32'h4000 + 32'(4 * i), 1'($urandom_range(0, 1)),
            14'($urandom), rv, head_torn(), 0);
    end
    while (mq.size() > 0) cycle(0, 0, 0, 0, 1, head_torn(), 0);
    idle(1);

    // Reset with entries in flight
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h500 + 32'(4 * i), 1, 14'h3, 0, 0, 0);
    cycle(1, 32'h5FF, 1, 0, 1, 1, 1);
    chk("mrst_up_en", 32'(PAs_up_en), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_ready", 32'(pre_ready), 1);
    chk("mrst_torf", 32'(torf), 1);
    chk("mrst_wr", 32'(PAs_wr_data), 0);
    chk("mrst_reen", 32'(gshare_reen), 0);
    chk("mrst_reghr", 32'(re_GHR), 0);
    chk("mrst_upaddr", up_addr, 0);
    chk("mrst_err", 32'(res_err), 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      a = $urandom;
      rv = ($urandom_range(0, 2) == 0);
      cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
            14'($urandom), rv,
            ($urandom_range(0, 7) != 0) ? head_torn() : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 149) == 0));
    end
    idle(3);
    chk("scoreboard_drained", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
